// File: rtl/rom_burst_reader.sv
// Burst sequencer for a combinational single-port ROM: walks consecutive addresses from a start
// point (wrapping modulo depth) and streams the words over a registered valid/ready output.
module rom_burst_reader #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] ck_q, ck_d;
  logic                  load;
  logic                  hs;

  // Output handshake: a word transfers on any edge where out_valid and out_ready are both high.
  // out_valid never drops without a transfer, and out_data is stable while stalled.
  assign hs = valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    data_d  = data_q;
    busy_d  = busy_q;
    ck_d    = ck_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = start_addr;
          rem_d   = burst_len;
          ck_d    = '0;
          busy_d  = 1'b1;
          state_d = (burst_len != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        // Refill the output register when it is empty or being drained this edge.
        load = (rem_q != '0) && (!valid_q || out_ready);
        if (hs) begin
          ck_d = ck_q + data_q;
          if (!load) valid_d = 1'b0;
          if (rem_q == '0) state_d = S_DONE;
        end
        if (load) begin
          data_d  = rom_data;
          valid_d = 1'b1;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      ck_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      ck_q    <= ck_d;
    end
  end

  assign rom_addr  = addr_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign busy      = busy_q;
  assign done      = (state_q == S_DONE);
  assign checksum  = ck_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: directed scenarios plus randomized bursts checked against a
// queue-based reference model of the ROM walk and checksum.
module tb_rom_burst_reader;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int LW = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] burst_len;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;
  logic [1:0]    dbg_state;

  logic [DW-1:0] rom_mem [DEPTH];
  assign rom_data = rom_mem[rom_addr];

  rom_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .burst_len(burst_len),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done), .checksum(checksum), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int hs_count = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: driven by the test
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_ck_q[$];
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [AW-1:0] prev_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: words are rom[(addr+i) mod depth], checksum is their sum mod 256
  task automatic start_burst(input int a, input int l);
    int sum = 0;
    for (int i = 0; i < l; i++) begin
      exp_q.push_back(rom_mem[(a + i) % DEPTH]);
      sum += rom_mem[(a + i) % DEPTH];
    end
    exp_ck_q.push_back(DW'(sum % 256));
    start = 1'b1;
    start_addr = AW'(a);
    burst_len = LW'(l);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_clear", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_checksum"}, checksum, 0);
  endtask

  // ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // scoreboard monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_valid_hold", out_valid, 1);
        check("stall_data_hold", out_data, prev_data);
        check("stall_addr_hold", rom_addr, prev_addr);
      end
      if (out_valid && out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
      if (done) begin
        check("words_before_done", exp_q.size(), 0);
        if (exp_ck_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done, expected none");
        end else begin
          check("checksum", checksum, exp_ck_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_addr = rom_addr;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = DW'(i);
    rst_n = 1'b1;
    start = 1'b0;
    start_addr = '0;
    burst_len = '0;
    out_ready = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;

    // 1: plain burst with latency checks
    start_burst(2, 4);
    @(negedge clk);
    check("t1_busy", busy, 1);
    check("t1_no_valid_yet", out_valid, 0);
    @(negedge clk);
    check("t1_first_valid", out_valid, 1);
    check("t1_first_data", out_data, 2);
    wait_done(50);

    // 2: wrapping burst
    start_burst(6, 5);
    wait_done(50);

    // 3: backpressure at the first word
    ready_mode = 2;
    out_ready = 1'b0;
    start_burst(0, 3);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t3_first_valid", out_valid, 1);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(50);
    ready_mode = 0;

    // 4: zero-length burst
    start_burst(4, 0);
    @(negedge clk);
    check("t4_done_next", done, 1);
    check("t4_no_valid", out_valid, 0);
    check("t4_checksum", checksum, 0);
    @(negedge clk);
    check("t4_done_one_cycle", done, 0);

    // 5: start while busy is ignored
    start_burst(2, 4);
    @(posedge clk);
    #1 start = 1'b1;
    start_addr = 3'd5;
    burst_len = 4'd8;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_done(50);

    // 6: reset in the middle of a burst
    n = hs_count;
    start_burst(0, 8);
    for (int i = 0; i < 30 && hs_count < n + 2; i++) @(negedge clk);
    check("t6_two_words", hs_count >= n + 2, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    exp_q.delete();
    exp_ck_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    start_burst(3, 6);
    wait_done(50);

    // randomized bursts with random ROM contents and random backpressure
    ready_mode = 1;
    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < DEPTH; i++) rom_mem[i] = DW'($urandom_range(0, 255));
      start_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, 15));
      wait_done(300);
    end

    repeat (5) @(negedge clk);
    check("final_words_left", exp_q.size(), 0);
    check("final_cksums_left", exp_ck_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
